// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receiver: start/data/even-parity/stop deserialiser
//
// Purpose:
//   Receives asynchronous serial frames on UART_Tx_IN. Each frame is a start
//   bit, WORD_LENGTH data bits (LSB first), an even parity bit and one stop
//   bit. Every bit is sampled at mid-bit using a baud counter running at
//   CLKS_PER_BIT = RX_CLKRATE / BAUD clocks per bit.
//
// Ports:
//   r_clk      in   receive clock, rising edge
//   r_rst      in   synchronous active-high reset
//   UART_Tx_IN in   serial line, idles high, asynchronous to r_clk
//   err_ack    out  one-cycle pulse on a completed frame with parity/framing error
//   UART_pckt  out  last correctly received data word, held until the next good frame
module uart_receiver #(
  parameter int WORD_LENGTH = 8,
  parameter int RX_CLKRATE  = 1000000,
  parameter int BAUD        = 9600
) (
  input  logic                   r_clk,
  input  logic                   r_rst,
  input  logic                   UART_Tx_IN,
  output logic                   err_ack,
  output logic [WORD_LENGTH-1:0] UART_pckt
);

  localparam int CLKS_PER_BIT = RX_CLKRATE / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_s;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       bit_idx;
  logic [WORD_LENGTH-1:0] shift;
  logic                   parity_ok;
  // Set once rx_s has been seen high in IDLE; a start needs a genuine 1->0
  // transition, so a line stuck low after a framing error cannot retrigger.
  logic                   armed;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_Tx_IN;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      parity_ok <= 1'b0;
      armed     <= 1'b0;
      UART_pckt <= '0;
      err_ack   <= 1'b0;
    end else begin
      err_ack <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= START;
          end
        end

        START: begin
          // Re-check the line half a bit into the start bit to reject glitches.
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
              state   <= PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            parity_ok <= ~(^shift ^ rx_s);
            state     <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          // Leave at mid-stop-bit so a start bit directly after the stop bit
          // is still caught; armed is cleared so the remaining high half of a
          // good stop bit re-arms, while a low stop bit does not.
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            armed <= 1'b0;
            if (rx_s && parity_ok) begin
              UART_pckt <= shift;
            end else begin
              err_ack <= 1'b1;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int CPB   = 1000000 / 9600;
  localparam int EARLY = CPB / 2 + 3;

  logic       r_clk = 1'b0;
  logic       r_rst;
  logic       UART_Tx_IN;
  logic       err_ack;
  logic [7:0] UART_pckt;

  int   vectors     = 0;
  int   miscompares = 0;
  int   err_pulses  = 0;
  bit   err_prev    = 1'b0;
  bit   long_pulse  = 1'b0;
  logic [7:0] early_pckt;
  logic [7:0] model_pckt;

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         stop;
    int         low_after;
    logic [7:0] exp_pckt;
    int         exp_err;
  } vec_t;

  vec_t tbl [9];

  uart_receiver #(
    .WORD_LENGTH(8),
    .RX_CLKRATE (1000000),
    .BAUD       (9600)
  ) dut (
    .r_clk     (r_clk),
    .r_rst     (r_rst),
    .UART_Tx_IN(UART_Tx_IN),
    .err_ack   (err_ack),
    .UART_pckt (UART_pckt)
  );

  always #5 r_clk = ~r_clk;

  // Counts err_ack pulses and flags any pulse longer than one cycle.
  always @(negedge r_clk) begin
    if (err_ack === 1'b1 && !err_prev) err_pulses++;
    if (err_ack === 1'b1 && err_prev) long_pulse = 1'b1;
    err_prev = (err_ack === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge r_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_bit);
    UART_Tx_IN = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      UART_Tx_IN = d[i];
      wait_cycles(CPB);
    end
    UART_Tx_IN = (^d) ^ bad_par;
    wait_cycles(CPB);
    UART_Tx_IN = stop_bit;
    wait_cycles(EARLY);
    early_pckt = UART_pckt;
    wait_cycles(CPB - EARLY);
  endtask

  initial begin
    int   p0;
    logic [7:0] d;
    bit   bad;
    bit   st;
    bit   good;

    tbl[0] = '{8'h55, 1'b1, 1'b1, 0,   8'h00, 1};
    tbl[1] = '{8'h55, 1'b0, 1'b1, 0,   8'h55, 0};
    tbl[2] = '{8'h55, 1'b1, 1'b1, 0,   8'h55, 1};
    tbl[3] = '{8'hA3, 1'b0, 1'b0, 0,   8'h55, 1};
    tbl[4] = '{8'hA3, 1'b0, 1'b1, 0,   8'hA3, 0};
    tbl[5] = '{8'h3C, 1'b0, 1'b0, 400, 8'hA3, 1};
    tbl[6] = '{8'h00, 1'b0, 1'b1, 0,   8'h00, 0};
    tbl[7] = '{8'hFF, 1'b0, 1'b1, 0,   8'hFF, 0};
    tbl[8] = '{8'h80, 1'b1, 1'b1, 0,   8'hFF, 1};

    // Reset with idle line
    r_rst      = 1'b1;
    UART_Tx_IN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_cycles(1);
      check("reset_pckt", {24'd0, UART_pckt}, 32'h00);
      check("reset_err", {31'd0, err_ack}, 32'd0);
    end
    r_rst = 1'b0;
    wait_cycles(20);

    // Table-driven frames
    for (int v = 0; v < 9; v++) begin
      p0 = err_pulses;
      send_frame(tbl[v].data, tbl[v].bad_par, tbl[v].stop);
      if (tbl[v].low_after > 0) begin
        UART_Tx_IN = 1'b0;
        wait_cycles(tbl[v].low_after);
      end
      UART_Tx_IN = 1'b1;
      wait_cycles(20);
      check($sformatf("tbl%0d_early_pckt", v), {24'd0, early_pckt}, {24'd0, tbl[v].exp_pckt});
      check($sformatf("tbl%0d_pckt", v), {24'd0, UART_pckt}, {24'd0, tbl[v].exp_pckt});
      check($sformatf("tbl%0d_err_pulses", v), err_pulses - p0, tbl[v].exp_err);
    end

    // 20 identical frames, no idle gap
    p0 = err_pulses;
    for (int k = 0; k < 20; k++) begin
      send_frame(8'h55, 1'b0, 1'b1);
      check($sformatf("b2b%0d_pckt", k), {24'd0, UART_pckt}, 32'h55);
    end
    check("b2b_err_pulses", err_pulses - p0, 0);
    model_pckt = 8'h55;

    // Randomized back-to-back frames against the reference model
    for (int k = 0; k < 20; k++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 4) != 0);
      p0  = err_pulses;
      send_frame(d, bad, st);
      if (!st) begin
        UART_Tx_IN = 1'b1;
        wait_cycles(20);
      end
      good = !bad && st;
      if (good) model_pckt = d;
      check($sformatf("rnd%0d_pckt d=%0h", k, d), {24'd0, UART_pckt}, {24'd0, model_pckt});
      check($sformatf("rnd%0d_err_pulses", k), err_pulses - p0, good ? 0 : 1);
    end
    UART_Tx_IN = 1'b1;
    wait_cycles(20);

    // 30-cycle low glitch on an idle line
    p0 = err_pulses;
    UART_Tx_IN = 1'b0;
    wait_cycles(30);
    UART_Tx_IN = 1'b1;
    wait_cycles(200);
    check("glitch_pckt", {24'd0, UART_pckt}, {24'd0, model_pckt});
    check("glitch_err_pulses", err_pulses - p0, 0);
    send_frame(8'h96, 1'b0, 1'b1);
    wait_cycles(20);
    check("post_glitch_pckt", {24'd0, UART_pckt}, 32'h96);

    // Reset in the middle of data bit 4
    UART_Tx_IN = 1'b0;
    wait_cycles(CPB);
    d = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      UART_Tx_IN = d[i];
      wait_cycles(CPB);
    end
    UART_Tx_IN = d[4];
    wait_cycles(CPB / 2);
    r_rst = 1'b1;
    wait_cycles(3);
    check("midreset_pckt", {24'd0, UART_pckt}, 32'h00);
    check("midreset_err", {31'd0, err_ack}, 32'd0);
    r_rst      = 1'b0;
    UART_Tx_IN = 1'b1;
    wait_cycles(300);
    p0 = err_pulses;
    send_frame(8'hC6, 1'b0, 1'b1);
    wait_cycles(20);
    check("after_reset_pckt", {24'd0, UART_pckt}, 32'hC6);
    check("after_reset_err_pulses", err_pulses - p0, 0);

    check("err_pulse_width_one", {31'd0, long_pulse}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Asynchronous serial (UART) receiver for one clock domain.
- Oversamples the serial line with a baud counter and samples each bit at mid-bit.
- Deserialises a frame of start bit, WORD_LENGTH data bits (LSB first), even parity bit and one stop bit.
- Presents the last good word in parallel and flags parity/framing errors. It sits behind the board-level RX pin and in front of the packet-consuming logic.

Parameters:
- WORD_LENGTH, 8, number of data bits per frame and width of UART_pckt.
- RX_CLKRATE, 1000000, r_clk frequency in Hz.
- BAUD, 9600, serial bit rate in bits/s.
- CLKS_PER_BIT, RX_CLKRATE/BAUD (104 at defaults), derived; r_clk cycles per bit. Baud counter width is clog2(CLKS_PER_BIT).

Ports:
- r_clk  input  1  receive clock; all logic is on the rising edge.
- r_rst  input  1  reset, synchronous and active-high.
- UART_Tx_IN  input  1  serial line from the remote transmitter; idles high; asynchronous to r_clk.
- err_ack  output  1  one-cycle pulse on a completed frame with a parity or framing error.
- UART_pckt  output  WORD_LENGTH  last correctly received data word.

Behaviour:
- Input synchronisation:
  - UART_Tx_IN passes through a 2-flop synchroniser; both flops reset to 1.
  - All decisions use the synchronised bit (rx_s), giving 2 cycles of fixed latency.
- Reset (r_rst=1 at a clock edge):
  - FSM goes to IDLE; baud counter, bit counter and shift register clear.
  - UART_pckt = 0, err_ack = 0.
  - Reset mid-frame abandons the frame and produces no output.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: counter held at 0. rx_s = 0 -> START, counter = 0.
- START:
  - Counter increments each cycle. When counter = CLKS_PER_BIT/2 - 1, sample rx_s.
  - rx_s = 1 is a false start (glitch) -> IDLE, no error.
  - rx_s = 0 -> DATA; counter = 0 and bit index = 0.
- DATA:
  - Counter runs 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1 (mid-bit) sample rx_s into shift register bit[index], LSB first; counter = 0.
  - After sampling index WORD_LENGTH-1 -> PARITY.
- PARITY: at CLKS_PER_BIT-1 sample the parity bit; parity_ok = (XOR of data bits XOR parity bit) == 0 (even parity); -> STOP.
- STOP: at CLKS_PER_BIT-1 sample the stop bit, then:
  - stop = 1 and parity_ok: UART_pckt <= shift register on the next edge; err_ack stays 0.
  - Otherwise: err_ack = 1 for exactly one cycle; UART_pckt keeps its previous value.
  - In both cases -> IDLE immediately, at mid-stop-bit.
- Back-to-back frames: because the FSM returns at mid-stop-bit, a start edge directly after the stop bit is detected. Continuous frames with no idle gap must be received without loss.
- Held outputs: UART_pckt holds its value until the next good frame; there is no valid strobe. err_ack is 0 at all other times.
- Line held low: a framing error is reported once. The FSM then re-enters START only after rx_s has been seen high in IDLE, i.e. IDLE requires a 1 -> 0 transition of rx_s.
- Counter limits: the baud counter never exceeds CLKS_PER_BIT-1; the bit index wraps to 0 at frame end.
- Simultaneous events: r_rst has priority over every state action.

Test Plan:
- Reset for 10 cycles with the line idle high -> UART_pckt = 0x00 and err_ack = 0 throughout; FSM stays in IDLE.
- One frame, 104 clocks per bit, bit sequence 0,1,0,1,0,1,0,1,0,0,1 (start, data 0x55 LSB first, parity 0, stop) -> UART_pckt = 0x55 within CLKS_PER_BIT/2+3 cycles after the stop-bit start; err_ack never asserts.
- 20 identical frames back-to-back with no idle gap -> UART_pckt = 0x55 after each frame; err_ack = 0; no frame missed (count 20 completions).
- Frame 0x55 with parity bit = 1 -> err_ack high for exactly 1 cycle; UART_pckt keeps its previous value (0x00 after reset, 0x55 if preceded by a good frame).
- Frame 0xA3 with stop bit = 0 -> err_ack 1-cycle pulse, UART_pckt unchanged. A following good frame 0xA3 (parity 0) -> UART_pckt = 0xA3.
- 30-cycle low glitch on an idle line -> false start rejected, no err_ack, UART_pckt unchanged.
- Reset asserted in the middle of data bit 4 -> outputs return to 0, and the next full frame is received correctly.
